// File: rtl/split_combiner.sv
// split_combiner: two-stage AND/priority-encode pipeline over split results, with per-batch
// satisfying/total counters and a drain/report handshake at each batch boundary.
module split_combiner #(
  parameter int NUM_SPLITS = 8,
  parameter int CNT_W      = 16,
  parameter int IDX_W      = $clog2(NUM_SPLITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_SPLITS-1:0] split_x,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sat,
  output logic [IDX_W-1:0]      out_fail_idx,
  output logic                  out_last,
  output logic [CNT_W-1:0]      run_sat,
  output logic [CNT_W-1:0]      run_total,
  output logic [CNT_W-1:0]      batch_sat,
  output logic [CNT_W-1:0]      batch_total,
  output logic                  batch_done
);
  typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;
  state_t state, state_nxt;
  logic                  s1_valid, s1_last, s1_load, s2_load, accept, out_hs;
  logic [NUM_SPLITS-1:0] s1_x;
  logic [IDX_W-1:0]      idx;
  assign s2_load    = !out_valid || out_ready;
  assign s1_load    = !s1_valid || s2_load;
  assign in_ready   = state == ACCUM && s1_load && !clear;
  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign batch_done = state == REPORT && !clear;
  // scanning downward lets the lowest failing bit win
  always_comb begin
    idx = '0;
    for (int i = NUM_SPLITS - 1; i >= 0; i--)
      if (!s1_x[i]) idx = IDX_W'(i);
  end
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   state_nxt = accept && in_last ? DRAIN : ACCUM;
      DRAIN:   state_nxt = out_hs && out_last ? REPORT : DRAIN;
      default: state_nxt = ACCUM;
    endcase
    if (clear) state_nxt = ACCUM;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCUM;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_x         <= '0;
      s1_last      <= 1'b0;
      out_valid    <= 1'b0;
      out_sat      <= 1'b0;
      out_fail_idx <= '0;
      out_last     <= 1'b0;
      run_sat      <= '0;
      run_total    <= '0;
      batch_sat    <= '0;
      batch_total  <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      run_sat   <= '0;
      run_total <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_x    <= split_x;
          s1_last <= in_last;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sat      <= &s1_x;
          out_fail_idx <= idx;
          out_last     <= s1_last;
        end
      end
      if (state == REPORT) begin
        batch_sat   <= run_sat;
        batch_total <= run_total;
        run_sat     <= '0;
        run_total   <= '0;
      end else if (out_hs) begin
        run_total <= run_total + CNT_W'(run_total != '1);
        if (out_sat) run_sat <= run_sat + CNT_W'(run_sat != '1);
      end
    end
endmodule
